// File: rtl/biu_arb.sv
// Bus interface arbiter: merges IFU fetches and LSU accesses onto a single
// memory port with one transaction outstanding and bounded LSU priority.
module biu_arb #(
  parameter int unsigned AW            = 32,
  parameter int unsigned DW            = 32,
  parameter int unsigned LSU_BURST_MAX = 4
) (
  input  logic            clk,
  input  logic            rst_n,

  input  logic            ifu2biu_req_vld,
  output logic            ifu2biu_req_rdy,
  input  logic [AW-1:0]   ifu2biu_req_pc,
  output logic            biu2ifu_rsp_vld,
  input  logic            biu2ifu_rsp_rdy,
  output logic [DW-1:0]   biu2ifu_rsp_inst,

  input  logic            lsu2biu_req_vld,
  output logic            lsu2biu_req_rdy,
  input  logic [AW-1:0]   lsu2biu_req_addr,
  input  logic [DW-1:0]   lsu2biu_req_wdata,
  input  logic            lsu2biu_req_we,
  input  logic [DW/8-1:0] lsu2biu_req_wstrb,
  output logic            biu2lsu_rsp_vld,
  input  logic            biu2lsu_rsp_rdy,
  output logic [DW-1:0]   biu2lsu_rsp_rdata,

  output logic            biu2mem_req_vld,
  input  logic            biu2mem_req_rdy,
  output logic [AW-1:0]   biu2mem_req_addr,
  output logic [DW-1:0]   biu2mem_req_wdata,
  output logic            biu2mem_req_we,
  output logic [DW/8-1:0] biu2mem_req_wstrb,
  input  logic            mem2biu_rsp_vld,
  output logic            mem2biu_rsp_rdy,
  input  logic [DW-1:0]   mem2biu_rsp_rdata
);

  localparam logic [3:0] BURST_MAX = 4'(LSU_BURST_MAX);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RSP
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              owner_lsu;
  logic [3:0]        gnt_cnt;
  logic [AW-1:0]     req_addr;
  logic [DW-1:0]     req_wdata;
  logic              req_we;
  logic [DW/8-1:0]   req_wstrb;

  logic              gnt_lsu;
  logic              gnt_ifu;
  logic              ifu_hs;
  logic              lsu_hs;
  logic              mem_req_hs;
  logic              mem_rsp_hs;

  // LSU normally wins; a waiting IFU gets through once the LSU burst budget is spent.
  always_comb begin
    gnt_lsu = lsu2biu_req_vld && !(ifu2biu_req_vld && (gnt_cnt == BURST_MAX));
    gnt_ifu = ifu2biu_req_vld && !gnt_lsu;
  end

  always_comb begin
    ifu_hs     = ifu2biu_req_vld && ifu2biu_req_rdy;
    lsu_hs     = lsu2biu_req_vld && lsu2biu_req_rdy;
    mem_req_hs = biu2mem_req_vld && biu2mem_req_rdy;
    mem_rsp_hs = mem2biu_rsp_vld && mem2biu_rsp_rdy;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ifu_hs || lsu_hs) state_nxt = REQ;
      REQ:     if (mem_req_hs)       state_nxt = RSP;
      RSP:     if (mem_rsp_hs)       state_nxt = IDLE;
      default:                       state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ifu2biu_req_rdy   = 1'b0;
    lsu2biu_req_rdy   = 1'b0;
    biu2mem_req_vld   = 1'b0;
    biu2ifu_rsp_vld   = 1'b0;
    biu2lsu_rsp_vld   = 1'b0;
    mem2biu_rsp_rdy   = 1'b0;
    biu2mem_req_addr  = req_addr;
    biu2mem_req_wdata = req_wdata;
    biu2mem_req_we    = req_we;
    biu2mem_req_wstrb = req_wstrb;
    biu2ifu_rsp_inst  = mem2biu_rsp_rdata;
    biu2lsu_rsp_rdata = mem2biu_rsp_rdata;
    case (state)
      IDLE: begin
        // rst_n gating keeps req_rdy low while reset is held
        ifu2biu_req_rdy = rst_n && gnt_ifu;
        lsu2biu_req_rdy = rst_n && gnt_lsu;
      end
      REQ: begin
        biu2mem_req_vld = 1'b1;
      end
      RSP: begin
        biu2ifu_rsp_vld = !owner_lsu && mem2biu_rsp_vld;
        biu2lsu_rsp_vld =  owner_lsu && mem2biu_rsp_vld;
        mem2biu_rsp_rdy = owner_lsu ? biu2lsu_rsp_rdy : biu2ifu_rsp_rdy;
      end
      default: begin
        ifu2biu_req_rdy = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_lsu <= 1'b0;
      gnt_cnt   <= '0;
      req_addr  <= '0;
      req_wdata <= '0;
      req_we    <= 1'b0;
      req_wstrb <= '0;
    end else if (ifu_hs) begin
      owner_lsu <= 1'b0;
      gnt_cnt   <= '0;
      req_addr  <= ifu2biu_req_pc;
      req_wdata <= '0;
      req_we    <= 1'b0;
      req_wstrb <= '0;
    end else if (lsu_hs) begin
      owner_lsu <= 1'b1;
      req_addr  <= lsu2biu_req_addr;
      req_wdata <= lsu2biu_req_wdata;
      req_we    <= lsu2biu_req_we;
      req_wstrb <= lsu2biu_req_wstrb;
      if (ifu2biu_req_vld && (gnt_cnt != BURST_MAX)) begin
        gnt_cnt <= gnt_cnt + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_biu_arb.sv
// Scoreboard bench for biu_arb: requester sources and a memory model run
// alongside directed scenarios; expected responses are queued at request time.
module tb_biu_arb;

  localparam byte G_I = 8'h49;
  localparam byte G_L = 8'h4C;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [3:0]  wstrb;
  } mreq_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ifu2biu_req_vld, ifu2biu_req_rdy;
  logic [31:0] ifu2biu_req_pc;
  logic        biu2ifu_rsp_vld, biu2ifu_rsp_rdy;
  logic [31:0] biu2ifu_rsp_inst;
  logic        lsu2biu_req_vld, lsu2biu_req_rdy;
  logic [31:0] lsu2biu_req_addr, lsu2biu_req_wdata;
  logic        lsu2biu_req_we;
  logic [3:0]  lsu2biu_req_wstrb;
  logic        biu2lsu_rsp_vld, biu2lsu_rsp_rdy;
  logic [31:0] biu2lsu_rsp_rdata;
  logic        biu2mem_req_vld, biu2mem_req_rdy;
  logic [31:0] biu2mem_req_addr, biu2mem_req_wdata;
  logic        biu2mem_req_we;
  logic [3:0]  biu2mem_req_wstrb;
  logic        mem2biu_rsp_vld, mem2biu_rsp_rdy;
  logic [31:0] mem2biu_rsp_rdata;

  logic [31:0] ifu_q[$];
  mreq_t       lsu_q[$];
  logic [31:0] ifu_exp[$];
  logic [31:0] lsu_exp[$];
  mreq_t       mreq_exp[$];
  byte         gnt_log[$];

  int unsigned ifu_acc = 0;
  int unsigned lsu_acc = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  bit          pending;
  logic [31:0] paddr;
  int          rsp_wait;
  int          stall_cnt;
  int          stall_cfg;
  int          rsp_delay_cfg;
  bit          spur_en;

  always #5 clk = ~clk;

  biu_arb #(
    .AW(32),
    .DW(32),
    .LSU_BURST_MAX(4)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .ifu2biu_req_vld   (ifu2biu_req_vld),
    .ifu2biu_req_rdy   (ifu2biu_req_rdy),
    .ifu2biu_req_pc    (ifu2biu_req_pc),
    .biu2ifu_rsp_vld   (biu2ifu_rsp_vld),
    .biu2ifu_rsp_rdy   (biu2ifu_rsp_rdy),
    .biu2ifu_rsp_inst  (biu2ifu_rsp_inst),
    .lsu2biu_req_vld   (lsu2biu_req_vld),
    .lsu2biu_req_rdy   (lsu2biu_req_rdy),
    .lsu2biu_req_addr  (lsu2biu_req_addr),
    .lsu2biu_req_wdata (lsu2biu_req_wdata),
    .lsu2biu_req_we    (lsu2biu_req_we),
    .lsu2biu_req_wstrb (lsu2biu_req_wstrb),
    .biu2lsu_rsp_vld   (biu2lsu_rsp_vld),
    .biu2lsu_rsp_rdy   (biu2lsu_rsp_rdy),
    .biu2lsu_rsp_rdata (biu2lsu_rsp_rdata),
    .biu2mem_req_vld   (biu2mem_req_vld),
    .biu2mem_req_rdy   (biu2mem_req_rdy),
    .biu2mem_req_addr  (biu2mem_req_addr),
    .biu2mem_req_wdata (biu2mem_req_wdata),
    .biu2mem_req_we    (biu2mem_req_we),
    .biu2mem_req_wstrb (biu2mem_req_wstrb),
    .mem2biu_rsp_vld   (mem2biu_rsp_vld),
    .mem2biu_rsp_rdy   (mem2biu_rsp_rdy),
    .mem2biu_rsp_rdata (mem2biu_rsp_rdata)
  );

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a == 32'h100) ? 32'h0000_0013 : ((a ^ 32'h5A5A_0000) + 32'd7);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Phase plan per cycle: drivers at negedge, main at +1, evaluators at +2.
  initial begin
    ifu2biu_req_vld = 1'b0;
    ifu2biu_req_pc  = '0;
    forever begin
      @(negedge clk);
      if (ifu_q.size() != 0) begin
        ifu2biu_req_vld = 1'b1;
        ifu2biu_req_pc  = ifu_q[0];
      end else begin
        ifu2biu_req_vld = 1'b0;
      end
      #2;
      if (ifu2biu_req_vld && ifu2biu_req_rdy) begin
        ifu_q.delete(0);
        ifu_exp.push_back(mem_data(ifu2biu_req_pc));
        mreq_exp.push_back('{ifu2biu_req_pc, 32'h0, 1'b0, 4'h0});
        gnt_log.push_back(G_I);
        ifu_acc++;
        if (lsu2biu_req_vld) check("ifu_gnt_lsu_rdy", 64'(lsu2biu_req_rdy), 64'(0));
      end
    end
  end

  initial begin
    lsu2biu_req_vld   = 1'b0;
    lsu2biu_req_addr  = '0;
    lsu2biu_req_wdata = '0;
    lsu2biu_req_we    = 1'b0;
    lsu2biu_req_wstrb = '0;
    forever begin
      @(negedge clk);
      if (lsu_q.size() != 0) begin
        lsu2biu_req_vld   = 1'b1;
        lsu2biu_req_addr  = lsu_q[0].addr;
        lsu2biu_req_wdata = lsu_q[0].wdata;
        lsu2biu_req_we    = lsu_q[0].we;
        lsu2biu_req_wstrb = lsu_q[0].wstrb;
      end else begin
        lsu2biu_req_vld = 1'b0;
      end
      #2;
      if (lsu2biu_req_vld && lsu2biu_req_rdy) begin
        lsu_q.delete(0);
        lsu_exp.push_back(mem_data(lsu2biu_req_addr));
        mreq_exp.push_back('{lsu2biu_req_addr, lsu2biu_req_wdata, lsu2biu_req_we, lsu2biu_req_wstrb});
        gnt_log.push_back(G_L);
        lsu_acc++;
        if (ifu2biu_req_vld) check("lsu_gnt_ifu_rdy", 64'(ifu2biu_req_rdy), 64'(0));
      end
    end
  end

  initial begin : mem_model
    mreq_t e;
    biu2mem_req_rdy   = 1'b0;
    mem2biu_rsp_vld   = 1'b0;
    mem2biu_rsp_rdata = '0;
    pending   = 1'b0;
    paddr     = '0;
    rsp_wait  = 0;
    stall_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pending         = 1'b0;
        stall_cnt       = 0;
        biu2mem_req_rdy = 1'b0;
        mem2biu_rsp_vld = 1'b0;
      end else begin
        if (biu2mem_req_vld && stall_cnt < stall_cfg) begin
          biu2mem_req_rdy = 1'b0;
          stall_cnt++;
        end else begin
          biu2mem_req_rdy = 1'b1;
        end
        if (pending) begin
          if (rsp_wait > 0) begin
            rsp_wait--;
            mem2biu_rsp_vld = 1'b0;
          end else begin
            mem2biu_rsp_vld   = 1'b1;
            mem2biu_rsp_rdata = mem_data(paddr);
          end
        end else begin
          mem2biu_rsp_vld   = spur_en;
          mem2biu_rsp_rdata = 32'hBAD0_BAD0;
        end
      end
      #2;
      if (mem2biu_rsp_vld && mem2biu_rsp_rdy) begin
        if (!pending) check("mem_rsp_rdy_spurious", 64'(1), 64'(0));
        pending = 1'b0;
      end
      if (biu2mem_req_vld && biu2mem_req_rdy) begin
        if (mreq_exp.size() == 0) begin
          check("mem_req_unexpected", 64'(1), 64'(0));
        end else begin
          e = mreq_exp.pop_front();
          check("mem_req_addr",  64'(biu2mem_req_addr),  64'(e.addr));
          check("mem_req_wdata", 64'(biu2mem_req_wdata), 64'(e.wdata));
          check("mem_req_we",    64'(biu2mem_req_we),    64'(e.we));
          check("mem_req_wstrb", 64'(biu2mem_req_wstrb), 64'(e.wstrb));
        end
        pending   = 1'b1;
        paddr     = biu2mem_req_addr;
        rsp_wait  = rsp_delay_cfg;
        stall_cnt = 0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (biu2ifu_rsp_vld) begin
        if (ifu_exp.size() == 0) check("ifu_rsp_unexpected", 64'(1), 64'(0));
        else if (biu2ifu_rsp_rdy) check("ifu_rsp_inst", 64'(biu2ifu_rsp_inst), 64'(ifu_exp.pop_front()));
      end
      if (biu2lsu_rsp_vld) begin
        if (lsu_exp.size() == 0) check("lsu_rsp_unexpected", 64'(1), 64'(0));
        else if (biu2lsu_rsp_rdy) check("lsu_rsp_rdata", 64'(biu2lsu_rsp_rdata), 64'(lsu_exp.pop_front()));
      end
    end
  end

  task automatic wait_acc(input bit is_lsu, input string tag);
    int unsigned base;
    base = is_lsu ? lsu_acc : ifu_acc;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      #1;
      if ((is_lsu ? lsu_acc : ifu_acc) != base) return;
    end
    check({tag, "_accept_timeout"}, 64'(0), 64'(1));
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      #1;
      if (ifu_q.size() == 0 && lsu_q.size() == 0 && ifu_exp.size() == 0 &&
          lsu_exp.size() == 0 && mreq_exp.size() == 0 && !pending && !biu2mem_req_vld) return;
    end
    check({tag, "_idle_timeout"}, 64'(0), 64'(1));
  endtask

  task automatic check_log(input string tag, input string exp);
    byte got;
    check({tag, "_count"}, 64'(gnt_log.size()), 64'(exp.len()));
    for (int i = 0; i < exp.len(); i++) begin
      got = (i < gnt_log.size()) ? gnt_log[i] : 8'h00;
      check($sformatf("%s_gnt%0d", tag, i), 64'(got), 64'(exp[i]));
    end
  endtask

  task automatic push_lsu(input logic [31:0] a, input logic [31:0] d, input logic we, input logic [3:0] s);
    lsu_q.push_back('{a, d, we, s});
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete (t=%0t)", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    rst_n           = 1'b0;
    biu2ifu_rsp_rdy = 1'b1;
    biu2lsu_rsp_rdy = 1'b1;
    stall_cfg       = 0;
    rsp_delay_cfg   = 0;
    spur_en         = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_mem_req_vld", 64'(biu2mem_req_vld), 64'(0));
    check("rst_ifu_rsp_vld", 64'(biu2ifu_rsp_vld), 64'(0));
    check("rst_lsu_rsp_vld", 64'(biu2lsu_rsp_vld), 64'(0));
    check("rst_mem_rsp_rdy", 64'(mem2biu_rsp_rdy), 64'(0));
    check("rst_mem_addr",    64'(biu2mem_req_addr), 64'(0));
    check("rst_mem_wdata",   64'(biu2mem_req_wdata), 64'(0));
    check("rst_mem_we",      64'(biu2mem_req_we), 64'(0));
    check("rst_mem_wstrb",   64'(biu2mem_req_wstrb), 64'(0));
    rst_n = 1'b1;

    // single fetch, response one cycle after the memory accepts
    rsp_delay_cfg = 1;
    ifu_q.push_back(32'h100);
    wait_acc(1'b0, "fetch");
    check("fetch_n1_req_vld", 64'(biu2mem_req_vld), 64'(1));
    check("fetch_n1_addr",    64'(biu2mem_req_addr), 64'(32'h100));
    check("fetch_n1_we",      64'(biu2mem_req_we), 64'(0));
    wait_idle("fetch");
    rsp_delay_cfg = 0;

    // memory back-pressure in REQ while the IFU waits
    stall_cfg = 5;
    push_lsu(32'h3000, 32'hCAFE_F00D, 1'b1, 4'h3);
    ifu_q.push_back(32'h400);
    wait_acc(1'b1, "stall");
    for (int i = 0; i < 5; i++) begin
      check("stall_req_vld", 64'(biu2mem_req_vld), 64'(1));
      check("stall_addr",    64'(biu2mem_req_addr), 64'(32'h3000));
      check("stall_wdata",   64'(biu2mem_req_wdata), 64'(32'hCAFE_F00D));
      check("stall_we",      64'(biu2mem_req_we), 64'(1));
      check("stall_wstrb",   64'(biu2mem_req_wstrb), 64'(4'h3));
      check("stall_ifu_rdy", 64'(ifu2biu_req_rdy), 64'(0));
      check("stall_lsu_rdy", 64'(lsu2biu_req_rdy), 64'(0));
      @(negedge clk);
      #1;
    end
    check("stall_release_req_vld", 64'(biu2mem_req_vld), 64'(1));
    @(negedge clk);
    #1;
    check("stall_rsp_state_req_vld", 64'(biu2mem_req_vld), 64'(0));
    check("stall_rsp_state_rsp_rdy", 64'(mem2biu_rsp_rdy), 64'(1));
    wait_idle("stall");
    stall_cfg = 0;

    // response back-pressure from the LSU
    biu2lsu_rsp_rdy = 1'b0;
    push_lsu(32'h2100, 32'h0, 1'b0, 4'h0);
    push_lsu(32'h2104, 32'h0, 1'b0, 4'h0);
    wait_acc(1'b1, "rspbp");
    @(negedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check("rspbp_lsu_rsp_vld", 64'(biu2lsu_rsp_vld), 64'(1));
      check("rspbp_mem_rsp_rdy", 64'(mem2biu_rsp_rdy), 64'(0));
      check("rspbp_lsu_req_rdy", 64'(lsu2biu_req_rdy), 64'(0));
      check("rspbp_mem_req_vld", 64'(biu2mem_req_vld), 64'(0));
      @(negedge clk);
      #1;
    end
    biu2lsu_rsp_rdy = 1'b1;
    #1;
    check("rspbp_release_rsp_rdy", 64'(mem2biu_rsp_rdy), 64'(1));
    wait_idle("rspbp");

    // spurious memory response while idle
    spur_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check("spur_mem_rsp_rdy", 64'(mem2biu_rsp_rdy), 64'(0));
      check("spur_ifu_rsp_vld", 64'(biu2ifu_rsp_vld), 64'(0));
      check("spur_lsu_rsp_vld", 64'(biu2lsu_rsp_vld), 64'(0));
    end
    spur_en = 1'b0;
    @(negedge clk);
    #1;

    // simultaneous requests: LSU first, IFU next
    gnt_log.delete();
    push_lsu(32'h2000, 32'h1122_3344, 1'b1, 4'hF);
    ifu_q.push_back(32'h500);
    wait_idle("both");
    check_log("both", "LI");

    // continuous contention exercises the burst limit
    gnt_log.delete();
    for (int i = 0; i < 8; i++) push_lsu(32'h8000 + 32'(i * 4), 32'h0, 1'b0, 4'h0);
    ifu_q.push_back(32'h600);
    ifu_q.push_back(32'h604);
    wait_idle("burst");
    check_log("burst", "LLLLILLLLI");

    // reset while in REQ with a non-zero grant counter
    gnt_log.delete();
    stall_cfg = 100;
    for (int i = 0; i < 3; i++) push_lsu(32'h9000 + 32'(i * 4), 32'h0, 1'b0, 4'h0);
    ifu_q.push_back(32'h700);
    wait_acc(1'b1, "rst");
    check("rstmid_req_vld_before", 64'(biu2mem_req_vld), 64'(1));
    rst_n = 1'b0;
    #1;
    check("rstmid_req_vld",  64'(biu2mem_req_vld), 64'(0));
    check("rstmid_addr",     64'(biu2mem_req_addr), 64'(0));
    check("rstmid_ifu_rdy",  64'(ifu2biu_req_rdy), 64'(0));
    check("rstmid_lsu_rdy",  64'(lsu2biu_req_rdy), 64'(0));
    check("rstmid_rsp_rdy",  64'(mem2biu_rsp_rdy), 64'(0));
    lsu_exp.delete();
    mreq_exp.delete();
    gnt_log.delete();
    stall_cfg = 0;
    push_lsu(32'h900C, 32'h0, 1'b0, 4'h0);
    push_lsu(32'h9010, 32'h0, 1'b0, 4'h0);
    @(negedge clk);
    #1;
    check("rsthold_lsu_rdy", 64'(lsu2biu_req_rdy), 64'(0));
    check("rsthold_ifu_rdy", 64'(ifu2biu_req_rdy), 64'(0));
    rst_n = 1'b1;
    wait_idle("rst");
    check_log("post_rst", "LLLLI");

    // mixed random traffic
    for (int r = 0; r < 6; r++) begin
      stall_cfg     = int'($urandom_range(0, 2));
      rsp_delay_cfg = int'($urandom_range(0, 2));
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) ifu_q.push_back($urandom & 32'hFFFF_FFFC);
      for (int k = 0; k < int'($urandom_range(1, 3)); k++)
        push_lsu($urandom, $urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      wait_idle("random");
    end

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
